// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: assembles 6-byte SD command frames from a UART
// receiver and presents them on a valid/ready interface.
// Optional build macro: UART_CMD_CRC_CHECK_EN (CRC7 check of byte 5).
module uart_cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned TO_W           = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_full,
   output logic        rx_keep,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        err_frame,
   output logic        err_crc,
   output logic        err_timeout,
   output logic        err_overrun,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK, S_PRESENT} state_t;

   localparam logic [TO_W-1:0] TO_TERM = TO_W'(TIMEOUT_CYCLES - 1);

   state_t          state_q, state_d;
   logic            rx_full_q;
   logic            rx_keep_q;
   logic [2:0]      cnt_q, cnt_d;
   logic [TO_W-1:0] to_q, to_d, to_inc;
   logic [5:0]      idx_q, idx_d;
   logic [31:0]     arg_q, arg_d;
   logic            stop_q, stop_d;
   logic            cmd_valid_q, cmd_valid_d;
   logic            err_frame_q, err_frame_d;
   logic            err_to_q, err_to_d;
   logic            err_ovr_q, err_ovr_d;
   logic            capture;
   logic            f_frame, f_to, f_ovr, f_hi;
`ifdef UART_CMD_CRC_CHECK_EN
   logic [6:0]      crc_rx_q, crc_rx_d;
   logic            err_crc_q, err_crc_d;
   logic            f_crc;

   // CRC7, polynomial x^7+x^3+1, init 0, MSB first
   function automatic logic [6:0] crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int unsigned i = 0; i < 40; i++) begin
         fb = d[39 - i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction
`endif

   assign capture = rx_full & ~rx_full_q;

   // Next-state, frame assembly and error selection
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      to_d        = to_q;
      to_inc      = to_q + 1'b1;
      idx_d       = idx_q;
      arg_d       = arg_q;
      stop_d      = stop_q;
      cmd_valid_d = cmd_valid_q;
      f_frame     = 1'b0;
      f_to        = 1'b0;
      f_ovr       = 1'b0;
`ifdef UART_CMD_CRC_CHECK_EN
      crc_rx_d    = crc_rx_q;
      f_crc       = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            to_d        = '0;
            cmd_valid_d = 1'b0;
            if (capture) begin
               if (rx_data[7:6] == 2'b01) begin
                  idx_d   = rx_data[5:0];
                  cnt_d   = 3'd1;
                  state_d = S_COLLECT;
               end else begin
                  f_frame = 1'b1;
               end
            end
         end
         S_COLLECT: begin
            // Argument bytes shift in MSB first; the stored byte 0
            // bits 7:6 are implicitly 01, so only bits 5:0 are kept.
            if (capture) begin
               to_d  = '0;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd5) begin
                  stop_d   = rx_data[0];
`ifdef UART_CMD_CRC_CHECK_EN
                  crc_rx_d = rx_data[7:1];
`endif
                  state_d  = S_CHECK;
               end else begin
                  arg_d = {arg_q[23:0], rx_data};
               end
            end else if (to_inc == TO_TERM) begin
               f_to    = 1'b1;
               to_d    = '0;
               state_d = S_IDLE;
            end else begin
               to_d = to_inc;
            end
         end
         S_CHECK: begin
            f_ovr = capture;
            if (!stop_q) begin
               f_frame = 1'b1;
               state_d = S_IDLE;
            end
`ifdef UART_CMD_CRC_CHECK_EN
            else if (crc_rx_q != crc7({2'b01, idx_q, arg_q})) begin
               f_crc   = 1'b1;
               state_d = S_IDLE;
            end
`endif
            else begin
               state_d = S_PRESENT;
            end
         end
         S_PRESENT: begin
            f_ovr       = capture;
            cmd_valid_d = 1'b1;
            if (cmd_valid_q && cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Only one error pulse per cycle: frame > crc > timeout > overrun
`ifdef UART_CMD_CRC_CHECK_EN
      f_hi      = f_frame | f_crc;
      err_crc_d = f_crc & ~f_frame;
`else
      f_hi      = f_frame;
`endif
      err_frame_d = f_frame;
      err_to_d    = f_to & ~f_hi;
      err_ovr_d   = f_ovr & ~f_hi & ~f_to;
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rx_full_q   <= 1'b0;
         rx_keep_q   <= 1'b1;
         cnt_q       <= '0;
         to_q        <= '0;
         idx_q       <= '0;
         arg_q       <= '0;
         stop_q      <= 1'b0;
         cmd_valid_q <= 1'b0;
         err_frame_q <= 1'b0;
         err_to_q    <= 1'b0;
         err_ovr_q   <= 1'b0;
`ifdef UART_CMD_CRC_CHECK_EN
         crc_rx_q    <= '0;
         err_crc_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rx_full_q   <= rx_full;
         rx_keep_q   <= ~capture;
         cnt_q       <= cnt_d;
         to_q        <= to_d;
         idx_q       <= idx_d;
         arg_q       <= arg_d;
         stop_q      <= stop_d;
         cmd_valid_q <= cmd_valid_d;
         err_frame_q <= err_frame_d;
         err_to_q    <= err_to_d;
         err_ovr_q   <= err_ovr_d;
`ifdef UART_CMD_CRC_CHECK_EN
         crc_rx_q    <= crc_rx_d;
         err_crc_q   <= err_crc_d;
`endif
      end
   end

`ifdef UART_CMD_CRC_CHECK_EN
   assign err_crc = err_crc_q;
`else
   assign err_crc = 1'b0;
`endif

   assign rx_keep     = rx_keep_q;
   assign cmd_index   = idx_q;
   assign cmd_arg     = arg_q;
   assign cmd_valid   = cmd_valid_q;
   assign err_frame   = err_frame_q;
   assign err_timeout = err_to_q;
   assign err_overrun = err_ovr_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed testbench for uart_cmd_sequencer with a command scoreboard.
module tb_uart_cmd_sequencer;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_full;
   logic        rx_keep;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        err_frame, err_crc, err_timeout, err_overrun;
   logic        busy;

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] arg;
   } cmd_t;

   cmd_t exp_q[$];

   int n_asrt = 0;
   int n_fail = 0;
   int n_frame = 0, n_crc = 0, n_to = 0, n_ovr = 0;

   logic        prev_valid = 1'b0;
   logic [5:0]  prev_idx   = '0;
   logic [31:0] prev_arg   = '0;

   always #5 clk = ~clk;

   uart_cmd_sequencer #(.TIMEOUT_CYCLES(TO), .TO_W(20)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_full     (rx_full),
      .rx_keep     (rx_keep),
      .cmd_index   (cmd_index),
      .cmd_arg     (cmd_arg),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .err_frame   (err_frame),
      .err_crc     (err_crc),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun),
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Error pulse bookkeeping and output stability while a command is held
   always @(negedge clk) begin
      if (err_frame)   n_frame++;
      if (err_crc)     n_crc++;
      if (err_timeout) n_to++;
      if (err_overrun) n_ovr++;
      if (err_frame | err_crc | err_timeout | err_overrun)
         chk("err_onehot", 32'($onehot({err_frame, err_crc, err_timeout, err_overrun})), 32'd1);
      if (prev_valid && cmd_valid) begin
         chk("idx_stable", 32'(cmd_index), 32'(prev_idx));
         chk("arg_stable", cmd_arg, prev_arg);
      end
      prev_valid <= cmd_valid;
      prev_idx   <= cmd_index;
      prev_arg   <= cmd_arg;
   end

   // One byte through the receiver model: flag raised, cleared by rx_keep=0
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b;
      rx_full = 1'b1;
      @(negedge clk);
      chk("keep_low", 32'(rx_keep), 32'd0);
      rx_full = 1'b0;
      @(negedge clk);
      chk("keep_high", 32'(rx_keep), 32'd1);
   endtask

   task automatic send_frame(input logic [47:0] f, input logic expect_cmd);
      cmd_t e;
      if (expect_cmd) begin
         e.idx = f[45:40];
         e.arg = f[39:8];
         exp_q.push_back(e);
      end
      for (int i = 0; i < 6; i++) send_byte(f[47 - 8*i -: 8]);
      if (expect_cmd) begin
         chk("valid_early", 32'(cmd_valid), 32'd0);
         @(negedge clk);
         chk("valid_rise", 32'(cmd_valid), 32'd1);
      end
   endtask

   task automatic wait_cmd();
      cmd_t e;
      for (int i = 0; i < 20 && !cmd_valid; i++) @(negedge clk);
      chk("valid_seen", 32'(cmd_valid), 32'd1);
      chk("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("cmd_index", 32'(cmd_index), 32'(e.idx));
         chk("cmd_arg", cmd_arg, e.arg);
      end
   endtask

   task automatic accept();
      cmd_ready = 1'b1;
      @(negedge clk);
      chk("accept_valid", 32'(cmd_valid), 32'd0);
      chk("accept_busy", 32'(busy), 32'd0);
      cmd_ready = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 32'(cmd_valid), 32'd0);
      chk({tag, "_idx"}, 32'(cmd_index), 32'd0);
      chk({tag, "_arg"}, cmd_arg, 32'd0);
      chk({tag, "_errs"}, 32'({err_frame, err_crc, err_timeout, err_overrun}), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_keep"}, 32'(rx_keep), 32'd1);
   endtask

   initial begin
      int e_tot, e_frame, e_ovr, e_to, e_crc;
      reset     = 1'b0;
      rx_full   = 1'b0;
      rx_data   = '0;
      cmd_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      reset = 1'b1;
      @(negedge clk);

      // Basic frame, accepted with cmd_ready
      send_frame(48'h40_00_00_00_00_95, 1'b1);
      wait_cmd();
      accept();

      // cmd_ready held high throughout: ignored until valid, then one-cycle handshake
      e_tot = n_frame + n_crc + n_to + n_ovr;
      cmd_ready = 1'b1;
      send_frame(48'h48_00_00_01_AA_87, 1'b1);
      wait_cmd();
      @(negedge clk);
      chk("ready_held_valid", 32'(cmd_valid), 32'd0);
      chk("ready_held_busy", 32'(busy), 32'd0);
      cmd_ready = 1'b0;
      #1;
      chk("no_errs", 32'(n_frame + n_crc + n_to + n_ovr - e_tot), 32'd0);

      // Bad CRC in byte 5
      e_crc = n_crc;
`ifdef UART_CMD_CRC_CHECK_EN
      send_frame(48'h40_00_00_00_00_97, 1'b0);
      repeat (4) @(negedge clk);
      chk("crc_no_valid", 32'(cmd_valid), 32'd0);
      #1;
      chk("crc_pulse", 32'(n_crc - e_crc), 32'd1);
`else
      send_frame(48'h40_00_00_00_00_97, 1'b1);
      wait_cmd();
      accept();
      #1;
      chk("crc_ignored", 32'(n_crc - e_crc), 32'd0);
`endif

      // Bad start byte
      e_frame = n_frame;
      send_byte(8'hC0);
      chk("frame_busy", 32'(busy), 32'd0);
      @(negedge clk);
      #1;
      chk("frame_pulse", 32'(n_frame - e_frame), 32'd1);
      send_frame(48'h48_00_00_01_AA_87, 1'b1);
      wait_cmd();
      accept();

      // Overrun while a command is held
      e_ovr = n_ovr;
      send_frame(48'h48_00_00_01_AA_87, 1'b1);
      wait_cmd();
      send_byte(8'h55);
      @(negedge clk);
      #1;
      chk("ovr_pulse", 32'(n_ovr - e_ovr), 32'd1);
      chk("ovr_valid", 32'(cmd_valid), 32'd1);
      chk("ovr_idx", 32'(cmd_index), 32'd8);
      chk("ovr_arg", cmd_arg, 32'h0000_01AA);
      accept();

      // Reset in the middle of a frame
      send_byte(8'h48);
      send_byte(8'h00);
      send_byte(8'h00);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk);
      reset = 1'b1;
      send_frame(48'h40_00_00_00_00_95, 1'b1);
      wait_cmd();
      accept();

      // Timeout: pulse 15 cycles after the last capture
      e_to = n_to;
      send_byte(8'h48);
      send_byte(8'h00);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         chk($sformatf("to_k%0d", k), 32'(err_timeout), 32'(k == 14));
      end
      chk("to_busy", 32'(busy), 32'd0);
      #1;
      chk("to_count", 32'(n_to - e_to), 32'd1);
      send_frame(48'h40_00_00_00_00_95, 1'b1);
      wait_cmd();
      accept();

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_cmd_sequencer.md
UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000; maximum idle clocks allowed between frame bytes.
REQ-002 SHALL have parameter TO_W, default 20; timeout counter width; TIMEOUT_CYCLES SHALL be less than 2^TO_W.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_data  in  8  byte from the UART receiver data output.
REQ-006 SHALL have port rx_full  in  1  receiver "contains data" status flag.
REQ-007 SHALL have port rx_keep  out  1  drives the receiver's "contains data" control input; 1 holds the flag, 0 clears it.
REQ-008 SHALL have port cmd_index  out  6  SD command index of the presented frame.
REQ-009 SHALL have port cmd_arg  out  32  SD command argument, MSB byte first on the wire.
REQ-010 SHALL have port cmd_valid  out  1  command present; held until accepted.
REQ-011 SHALL have port cmd_ready  in  1  downstream accept.
REQ-012 SHALL have ports err_frame, err_crc, err_timeout, err_overrun  out  1 each  one-cycle error pulses.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL capture rx_data only on a rising edge of rx_full (rx_full=1 with registered previous value 0).
REQ-015 SHALL drive rx_keep=0 for exactly the one cycle after each capture and rx_keep=1 otherwise.
REQ-016 SHALL implement states IDLE, COLLECT, CHECK and PRESENT.
REQ-017 IDLE: a captured byte with bits[7:6]=01 SHALL be stored as byte 0, set the byte count to 1 and enter COLLECT; any other byte SHALL pulse err_frame and remain in IDLE.
REQ-018 COLLECT: captured bytes SHALL be stored as bytes 1..5; after byte 5 the FSM SHALL enter CHECK.
REQ-019 CHECK: lasts one cycle; byte 5 bit0=0 SHALL pulse err_frame and return to IDLE; otherwise the FSM SHALL enter PRESENT (subject to REQ-029).
REQ-020 cmd_valid SHALL rise on the second rising clock edge after the edge that captures byte 5.
REQ-021 PRESENT: cmd_index=byte0[5:0] and cmd_arg={byte1,byte2,byte3,byte4}; both SHALL stay stable while cmd_valid=1.
REQ-022 PRESENT: on a cycle where cmd_valid=1 and cmd_ready=1, the FSM SHALL enter IDLE with cmd_valid=0 on the next cycle.
REQ-023 cmd_ready SHALL be ignored while cmd_valid=0.
REQ-024 A byte captured in CHECK or PRESENT SHALL be dropped, SHALL still be cleared per REQ-015, and SHALL pulse err_overrun.
REQ-025 COLLECT: the TO_W-bit counter SHALL clear on each capture and increment otherwise; reaching TIMEOUT_CYCLES-1 SHALL pulse err_timeout and return the FSM to IDLE, discarding the partial frame.
REQ-026 If a capture and the timeout terminal count occur in the same cycle, the capture SHALL win and no timeout SHALL occur.
REQ-027 At most one error pulse SHALL assert per cycle; priority is frame, crc, timeout, overrun.

Reset
REQ-028 When reset=0, the block SHALL asynchronously enter IDLE with cmd_valid=0, cmd_index=0, cmd_arg=0, all err_*=0, busy=0, rx_keep=1, counters=0 and the rx_full edge register=0; a partial frame SHALL be discarded.

Configuration
REQ-029 With UART_CMD_CRC_CHECK_EN defined, CHECK SHALL compare byte5[7:1] against the CRC7 (x^7+x^3+1, init 0, MSB first) of bytes 0-4; on mismatch it SHALL pulse err_crc and return to IDLE.
REQ-030 Without UART_CMD_CRC_CHECK_EN, byte5[7:1] SHALL be ignored, err_crc SHALL be tied to 0, and no CRC logic SHALL be instantiated.

Verification
REQ-031 The bench SHALL send bytes 40 00 00 00 00 95 -> cmd_valid=1, cmd_index=0, cmd_arg=0x00000000; then assert cmd_ready -> IDLE on the next cycle.
REQ-032 The bench SHALL send 48 00 00 01 AA 87 -> cmd_index=8, cmd_arg=0x000001AA, no error pulses.
REQ-033 The bench SHALL send 40 00 00 00 00 97 with CRC_EN -> one err_crc pulse and no cmd_valid; without CRC_EN -> cmd_valid=1.
REQ-034 The bench SHALL send C0 -> err_frame pulse, busy stays 0; then send a valid frame -> accepted normally.
REQ-035 With TIMEOUT_CYCLES=16, the bench SHALL send 48 00 then stay silent -> err_timeout exactly 15 cycles after the last capture, then IDLE.
REQ-036 The bench SHALL hold cmd_ready=0 and send byte 0x55 during PRESENT -> err_overrun pulse, cmd_arg unchanged; reset=0 mid-COLLECT -> all outputs at REQ-028 values.
